// File: rtl/pc_ctrl_pkg.sv
// Shared encodings and default addresses for the PC redirect controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } pc_state_e;

  // Numeric order doubles as redirect priority.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    JUMP   = 2'd1,
    BRANCH = 2'd2,
    TRAP   = 2'd3
  } redirect_cls_e;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0040_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0040_0100;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Priority select among trap, branch and jump requests (trap > branch > jump).
module pc_redirect_arbiter
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     N           = 32,
  parameter logic [N-1:0]    TRAP_VECTOR = TRAP_VECTOR_DEF
) (
  input  logic          trap_req,
  input  logic          branch_req,
  input  logic [N-1:0]  branch_target,
  input  logic          jump_req,
  input  logic [N-1:0]  jump_target,
  output redirect_cls_e cls,
  output logic [N-1:0]  target,
  output logic          flush_if,
  output logic          flush_id
);

  // Highest-priority active request wins.
  always_comb begin
    cls      = NONE;
    target   = '0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    if (trap_req) begin
      cls      = TRAP;
      target   = TRAP_VECTOR;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (branch_req) begin
      cls      = BRANCH;
      target   = branch_target;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (jump_req) begin
      cls      = JUMP;
      target   = jump_target;
      flush_if = 1'b1;
      flush_id = 1'b0;
    end else begin
      cls      = NONE;
      target   = '0;
      flush_if = 1'b0;
      flush_id = 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_controller.sv
// Next-PC sequencing: PC+4, jump/branch redirects, stall buffering and trap drain.
module pc_redirect_controller
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned  N            = 32,
  parameter logic [N-1:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [N-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int unsigned  DRAIN_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_i,
  input  logic         fetch_stall_i,
  input  logic         jump_i,
  input  logic [N-1:0] jump_target_i,
  input  logic         branch_i,
  input  logic [N-1:0] branch_target_i,
  input  logic         trap_i,
  output logic [N-1:0] next_pc_o,
  output logic         flush_if_o,
  output logic         flush_id_o,
  output logic         busy_o
);

  localparam logic [3:0]   DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [N-1:0] PC_STEP    = {{(N-3){1'b0}}, 3'b100};

  pc_state_e     state_r, state_s;
  redirect_cls_e pend_cls_r, pend_cls_s;
  logic [N-1:0]  pend_pc_r, pend_pc_s;
  logic [3:0]    cnt_r, cnt_s;

  redirect_cls_e arb_cls_s;
  logic [N-1:0]  arb_tgt_s;
  logic          arb_fif_s, arb_fid_s;

  pc_redirect_arbiter #(.N(N), .TRAP_VECTOR(TRAP_VECTOR)) u_arb (
    .trap_req      (trap_i),
    .branch_req    (branch_i),
    .branch_target (branch_target_i),
    .jump_req      (jump_i),
    .jump_target   (jump_target_i),
    .cls           (arb_cls_s),
    .target        (arb_tgt_s),
    .flush_if      (arb_fif_s),
    .flush_id      (arb_fid_s)
  );

  // Next-state, pending-slot and zero-latency output decode.
  always_comb begin
    state_s    = state_r;
    pend_cls_s = pend_cls_r;
    pend_pc_s  = pend_pc_r;
    cnt_s      = cnt_r;
    next_pc_o  = pc_i;
    flush_if_o = 1'b0;
    flush_id_o = 1'b0;
    busy_o     = 1'b0;
    if (reset) begin
      next_pc_o = RESET_PC;
    end else begin
      busy_o = (state_r != RUN);
      case (state_r)
        RUN, PEND: begin
          if (trap_i) begin
            state_s    = DRAIN;
            cnt_s      = DRAIN_INIT;
            pend_cls_s = NONE;
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
          end else if (state_r == RUN) begin
            if (arb_cls_s != NONE) begin
              flush_if_o = arb_fif_s;
              flush_id_o = arb_fid_s;
              if (fetch_stall_i) begin
                pend_pc_s  = arb_tgt_s;
                pend_cls_s = arb_cls_s;
                state_s    = PEND;
              end else begin
                next_pc_o = arb_tgt_s;
              end
            end else begin
              next_pc_o = fetch_stall_i ? pc_i : pc_i + PC_STEP;
            end
          end else begin
            // Only a strictly younger-and-stronger redirect may displace the buffered one.
            if (arb_cls_s > pend_cls_r) begin
              pend_pc_s  = arb_tgt_s;
              pend_cls_s = arb_cls_s;
              flush_if_o = arb_fif_s;
              flush_id_o = arb_fid_s;
            end else begin
              pend_pc_s = pend_pc_r;
            end
            if (!fetch_stall_i) begin
              next_pc_o  = pend_pc_s;
              pend_cls_s = NONE;
              state_s    = RUN;
            end else begin
              next_pc_o = pc_i;
            end
          end
        end
        DRAIN: begin
          flush_if_o = 1'b1;
          flush_id_o = 1'b1;
          if (cnt_r == 4'd0) begin
            if (!fetch_stall_i) begin
              next_pc_o = TRAP_VECTOR;
              state_s   = RUN;
            end else begin
              next_pc_o = pc_i;
            end
          end else begin
            cnt_s = cnt_r - 4'd1;
          end
        end
        default: begin
          state_s = RUN;
        end
      endcase
    end
  end

  // State, pending slot and drain counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      pend_cls_r <= NONE;
      pend_pc_r  <= '0;
      cnt_r      <= 4'd0;
    end else begin
      state_r    <= state_s;
      pend_cls_r <= pend_cls_s;
      pend_pc_r  <= pend_pc_s;
      cnt_r      <= cnt_s;
    end
  end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_pc_redirect_controller;

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] TVEC    = 32'h0040_0100;
  localparam int          DRAIN_N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_i = 32'h0;
  logic        fetch_stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = 32'h0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        trap_i = 1'b0;
  logic [31:0] next_pc_o;
  logic        flush_if_o, flush_id_o, busy_o;

  pc_redirect_controller #(
    .N(32), .RESET_PC(RST_PC), .TRAP_VECTOR(TVEC), .DRAIN_CYCLES(DRAIN_N)
  ) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .fetch_stall_i(fetch_stall_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i), .trap_i(trap_i),
    .next_pc_o(next_pc_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    bit          fi;
    bit          fd;
    bit          busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: an abstract view of "what the PC unit owes the pipeline".
  bit          draining = 1'b0;
  int          drain_left = 0;
  bit          have_pend = 1'b0;
  int          pend_rank = 0;
  logic [31:0] pend_target = 32'h0;
  logic [31:0] mpc = 32'h0;

  task automatic step(input bit rst, input logic [31:0] pc, input bit stall,
                      input bit j, input logic [31:0] jt,
                      input bit b, input logic [31:0] bt,
                      input bit tr, input string tag);
    exp_t e;
    int rank;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    reset = rst; pc_i = pc; fetch_stall_i = stall;
    jump_i = j; jump_target_i = jt; branch_i = b; branch_target_i = bt; trap_i = tr;
    e.tag = tag; e.pc = pc; e.fi = 1'b0; e.fd = 1'b0; e.busy = 1'b0;
    rank = b ? 2 : (j ? 1 : 0);
    tgt  = b ? bt : jt;
    if (rst) begin
      e.pc = RST_PC;
      draining = 1'b0; have_pend = 1'b0;
    end else if (draining) begin
      e.fi = 1'b1; e.fd = 1'b1; e.busy = 1'b1;
      if (drain_left == 0 && !stall) begin
        e.pc = TVEC;
        draining = 1'b0;
      end else if (drain_left > 0) begin
        drain_left--;
      end
    end else if (tr) begin
      e.fi = 1'b1; e.fd = 1'b1; e.busy = have_pend;
      draining = 1'b1; drain_left = DRAIN_N - 1; have_pend = 1'b0;
    end else if (have_pend) begin
      e.busy = 1'b1;
      if (rank > pend_rank) begin
        pend_rank = rank; pend_target = tgt;
        e.fi = 1'b1; e.fd = (rank == 2);
      end
      if (!stall) begin
        e.pc = pend_target;
        have_pend = 1'b0;
      end
    end else if (rank > 0) begin
      e.fi = 1'b1; e.fd = (rank == 2);
      if (stall) begin
        have_pend = 1'b1; pend_rank = rank; pend_target = tgt;
      end else begin
        e.pc = tgt;
      end
    end else begin
      e.pc = stall ? pc : pc + 32'd4;
    end
    mpc = e.pc;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s %s got=%h expected=%h", tag, what, got, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare once per negedge while expectations wait.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "next_pc",  next_pc_o, e.pc);
        chk(e.tag, "flush_if", {31'd0, flush_if_o}, {31'd0, e.fi});
        chk(e.tag, "flush_id", {31'd0, flush_id_o}, {31'd0, e.fd});
        chk(e.tag, "busy",     {31'd0, busy_o}, {31'd0, e.busy});
      end
    end
  end

  initial begin
    bit prev_trap;
    bit tr, b, j, s, r;
    logic [31:0] pcv;
    // Reset with arbitrary PC, then sequential fetch.
    step(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset0");
    step(1'b1, $urandom, 1'b1, 1'b1, 32'h1234, 1'b1, 32'h5678, 1'b1, "reset1");
    step(1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "seq");
    // Branch and jump together: branch target, both flushes.
    step(1'b0, 32'h0040_0010, 1'b0, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0080, 1'b0, "br_jmp");
    step(1'b0, 32'h0040_0080, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "after_br");
    // Stalled jump upgraded by a branch, released after the stall.
    step(1'b0, 32'h0040_0084, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0, 1'b0, "stall_jmp");
    step(1'b0, 32'h0040_0084, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "stall_c1");
    step(1'b0, 32'h0040_0084, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0090, 1'b0, "stall_br");
    step(1'b0, 32'h0040_0084, 1'b1, 1'b1, 32'h0040_0777, 1'b0, 32'h0, 1'b0, "stall_low");
    step(1'b0, 32'h0040_0084, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "release");
    step(1'b0, 32'h0040_0090, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "post_rel");
    // Trap drain with an ignored branch.
    step(1'b0, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "trap");
    step(1'b0, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0abc, 1'b0, "drain1");
    step(1'b0, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "vector");
    // Drain end held by a stall.
    step(1'b0, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "trap2");
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0300, 1'b0, 32'h0, 1'b0, "drain_hold");
    step(1'b0, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "vector2");
    // Reset mid-drain: saved trap must never surface.
    step(1'b0, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "trap3");
    step(1'b1, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rst_drain");
    for (int i = 0; i < 4; i++)
      step(1'b0, RST_PC + 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "post_rst");
    // Wrap at the top of the address space.
    step(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "wrap");
    // Randomized traffic with the PC fed back from the model.
    prev_trap = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(63) == 0);
      s   = ($urandom_range(2) == 0);
      j   = ($urandom_range(5) == 0);
      b   = ($urandom_range(7) == 0);
      tr  = ($urandom_range(19) == 0) && !prev_trap;
      pcv = ($urandom_range(15) == 0) ? $urandom : mpc;
      step(r, pcv, s, j, $urandom, b, $urandom, tr, "rand");
      prev_trap = tr;
    end
    step(1'b0, mpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "tail");
    repeat (3) @(negedge clk);
    chk("drain", "sb_left", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
